// File: rtl/onehot_encode8to3.sv
// Line-vector to select-code encoder: emits one 3-bit code per set line,
// highest line first, over a valid/ready stream. Inverse of the 3-to-8 decoder.
module onehot_encode8to3 #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_vec,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] code,
  output logic          code_valid,
  input  logic          code_ready,
  output logic          code_last,
  output logic [CW:0]   bit_cnt,
  output logic          err_zero
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [CW:0]   bit_cnt_q, bit_cnt_d;
  logic          err_zero_q, err_zero_d;
  logic [CW-1:0] hi_idx;

  function automatic logic [CW:0] popcount(input logic [N-1:0] v);
    logic [CW:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + {{CW{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      bit_cnt_q  <= '0;
      err_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      bit_cnt_q  <= bit_cnt_d;
      err_zero_q <= err_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    bit_cnt_d  = bit_cnt_q;
    err_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (|in_vec) begin
            pending_d = in_vec;
            bit_cnt_d = popcount(in_vec);
            state_d   = SCAN;
          end else begin
            err_zero_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (code_ready) begin
          pending_d[hi_idx] = 1'b0;
          if (code_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so stalls keep code stable.
  always_comb begin
    hi_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_q[i]) hi_idx = CW'(i);
    end
    in_ready   = (state_q == IDLE);
    code_valid = (state_q == SCAN);
    code       = code_valid ? (CW'(N - 1) - hi_idx) : '0;
    code_last  = code_valid && (pending_q != '0) &&
                 ((pending_q & (pending_q - {{(N-1){1'b0}}, 1'b1})) == '0);
  end

  assign bit_cnt  = bit_cnt_q;
  assign err_zero = err_zero_q;

endmodule

// File: tb/tb_onehot_encode8to3.sv
// Directed bench for onehot_encode8to3: fixed vectors plus a sweep of all
// non-zero vectors reconstructed through a reference 3-to-8 decoder.
module tb_onehot_encode8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       code_last;
  logic [3:0] bit_cnt;
  logic       err_zero;

  int total = 0;
  int bad   = 0;

  onehot_encode8to3 #(.N(8), .CW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vec     (in_vec),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_last  (code_last),
    .bit_cnt    (bit_cnt),
    .err_zero   (err_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents vec, then drains the burst comparing each beat against a list
  // of codes derived from vec (bit 7-k -> code k).
  task automatic burst(input logic [7:0] vec, input bit toggle, input bit hold_valid);
    logic [2:0] exp_codes[$];
    logic [7:0] recon;
    logic [3:0] exp_cnt;
    int idx;
    int cyc;
    exp_cnt = '0;
    for (int k = 0; k < 8; k++) begin
      if (vec[7-k]) begin
        exp_codes.push_back(3'(k));
        exp_cnt = exp_cnt + 4'd1;
      end
    end
    check("acc_ready", in_ready, 1);
    in_vec     = vec;
    in_valid   = 1'b1;
    code_ready = 1'b1;
    step();
    in_valid = hold_valid;
    in_vec   = 8'h55;
    check("bit_cnt", bit_cnt, exp_cnt);
    idx = 0;
    cyc = 0;
    recon = '0;
    while (idx < exp_codes.size() && cyc < 40) begin
      code_ready = toggle ? ~cyc[0] : 1'b1;
      check("beat_valid", code_valid, 1);
      check("beat_in_ready", in_ready, 0);
      check("beat_code", code, exp_codes[idx]);
      check("beat_last", code_last, (idx == exp_codes.size() - 1));
      check("beat_bit_cnt", bit_cnt, exp_cnt);
      if (code_ready) begin
        recon = recon | (8'h80 >> code);
        idx++;
      end
      step();
      cyc++;
    end
    in_valid   = 1'b0;
    code_ready = 1'b0;
    check("burst_beats", idx, exp_codes.size());
    check("burst_cycles", cyc, toggle ? 2 * exp_codes.size() - 1 : exp_codes.size());
    check("post_valid", code_valid, 0);
    check("post_ready", in_ready, 1);
    check("post_bit_cnt", bit_cnt, exp_cnt);
    check("recon", recon, vec);
  endtask

  initial begin
    rst        = 1'b1;
    in_vec     = 8'hFF;
    in_valid   = 1'b1;
    code_ready = 1'b1;
    step();
    step();
    check("rst_ready", in_ready, 1);
    check("rst_valid", code_valid, 0);
    check("rst_last", code_last, 0);
    check("rst_code", code, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_err", err_zero, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_vec   = 8'h00;

    // single top line: one beat, code 000, last
    in_vec   = 8'b1000_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_code", code, 3'b000);
    check("t1_valid", code_valid, 1);
    check("t1_last", code_last, 1);
    check("t1_bit_cnt", bit_cnt, 1);
    check("t1_ready_busy", in_ready, 0);
    step();
    check("t1_ready_after", in_ready, 1);
    check("t1_valid_after", code_valid, 0);

    burst(8'b0010_0101, 1'b0, 1'b0);
    burst(8'hFF, 1'b1, 1'b1);

    // all-zero vector: one-cycle error pulse, no code
    in_vec   = 8'h00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("z_err", err_zero, 1);
    check("z_valid", code_valid, 0);
    check("z_ready", in_ready, 1);
    check("z_bit_cnt_held", bit_cnt, 8);
    step();
    check("z_err_clear", err_zero, 0);
    check("z_valid2", code_valid, 0);

    // reset mid-burst after two handshakes
    in_vec     = 8'hC3;
    in_valid   = 1'b1;
    code_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("r_code0", code, 3'd0);
    step();
    check("r_code1", code, 3'd1);
    step();
    check("r_code2", code, 3'd6);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_vec   = 8'hFF;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("r_valid", code_valid, 0);
    check("r_ready", in_ready, 1);
    check("r_bit_cnt", bit_cnt, 0);
    burst(8'h01, 1'b0, 1'b0);

    for (int v = 1; v < 256; v++) begin
      burst(8'(v), v[0], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
